// File: rtl/lfsr_perm_pkg.sv
// Shared types and constants for the permuted Galois LFSR generator.
package lfsr_perm_pkg;

    // Reseed controller states.
    typedef enum logic [1:0] {
        ST_UNSEEDED = 2'd0,
        ST_RUN      = 2'd1,
        ST_EXPIRED  = 2'd2
    } reseed_state_e;

    // Permutation table of the classic 64-bit, 6-bit-index configuration.
    typedef logic [63:0][5:0] lfsr_perm64_t;

    localparam logic [63:0] DEFAULT_TAP_MASK = 64'hD800_0000_0000_0000;
    localparam logic [63:0] DEFAULT_SEED     = 64'h1;

    // Identity permutation for a state of 'width' bits. Entries are packed
    // back to back with a stride of $clog2(width) bits from bit 0 upward, so
    // truncating the result to width*$clog2(width) bits gives exactly the
    // layout of a logic [width-1:0][$clog2(width)-1:0] table.
    function automatic lfsr_perm64_t identity_perm(int unsigned width);
        logic [64*6-1:0] flat;
        int unsigned     w;
        flat = '0;
        w    = $clog2(width);
        for (int unsigned i = 0; i < width && i < 64; i++) begin
            for (int unsigned b = 0; b < 6; b++) begin
                if (b < w) flat[i*w + b] = i[b];
            end
        end
        return flat;
    endfunction

endpackage

// File: rtl/lfsr_perm_reseed_ctrl.sv
// Reseed policy: tracks seeded/expired status and counts steps since the
// last accepted seed. Decides when the LFSR datapath may step.
module lfsr_perm_reseed_ctrl
    import lfsr_perm_pkg::*;
#(
    parameter int unsigned ReseedInterval = 1024,
    parameter bit          StallOnExpiry  = 1'b1
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic en_i,
    input  logic seed_accept_i,
    output logic step_o,
    output logic rnd_valid_o,
    output logic reseed_req_o
);

    localparam int unsigned      CntW   = $clog2(ReseedInterval + 1);
    localparam logic [CntW-1:0]  CntMax = CntW'(ReseedInterval);

    reseed_state_e   state_q;
    logic [CntW-1:0] cnt_q;
    logic [CntW-1:0] cnt_inc;

    // A step only happens while running, and a same-cycle seed takes priority.
    // In stall mode RUN always has cnt_q < CntMax, since reaching the limit
    // leaves RUN on the same edge.
    assign step_o = en_i && (state_q == ST_RUN) && !seed_accept_i;

    // Saturating increment of the step counter.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can
        // leave it unassigned and infer a latch.
        cnt_inc = cnt_q;
        if (cnt_q != CntMax) cnt_inc = cnt_q + 1'b1;
    end

    // FSM, step counter and registered status outputs.
    always_ff @(posedge clk_i) begin
        // NOTE: reset is sampled on the clock edge; state uses non-blocking
        // assignments so all registers update together from pre-edge values.
        if (rst_i) begin
            state_q      <= ST_UNSEEDED;
            cnt_q        <= '0;
            rnd_valid_o  <= 1'b0;
            reseed_req_o <= 1'b1;
        end else if (seed_accept_i) begin
            state_q      <= ST_RUN;
            cnt_q        <= '0;
            rnd_valid_o  <= 1'b1;
            reseed_req_o <= 1'b0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (step_o) begin
                        cnt_q <= cnt_inc;
                        if (cnt_inc == CntMax) begin
                            reseed_req_o <= 1'b1;
                            if (StallOnExpiry) begin
                                state_q     <= ST_EXPIRED;
                                rnd_valid_o <= 1'b0;
                            end
                        end
                    end
                end
                ST_UNSEEDED, ST_EXPIRED: begin
                    rnd_valid_o  <= 1'b0;
                    reseed_req_o <= 1'b1;
                end
                default: begin
                    state_q      <= ST_UNSEEDED;
                    rnd_valid_o  <= 1'b0;
                    reseed_req_o <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: rtl/lfsr_perm_gen.sv
// Parametrised Galois LFSR with a fixed output bit permutation, a seed load
// handshake and reseed accounting. The datapath and permutation live here;
// the reseed policy is in lfsr_perm_reseed_ctrl.
module lfsr_perm_gen
    import lfsr_perm_pkg::*;
#(
    parameter int unsigned LfsrDw         = 64,
    parameter int unsigned OutDw          = LfsrDw,
    parameter int unsigned PermIdxW       = $clog2(LfsrDw),
    parameter logic [LfsrDw-1:0] TapMask     = LfsrDw'(DEFAULT_TAP_MASK),
    parameter logic [LfsrDw-1:0] DefaultSeed = LfsrDw'(DEFAULT_SEED),
    parameter logic [LfsrDw-1:0][PermIdxW-1:0] Perm =
        (LfsrDw*PermIdxW)'(identity_perm(LfsrDw)),
    parameter int unsigned ReseedInterval = 1024,
    parameter bit          StallOnExpiry  = 1'b1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              en_i,
    input  logic              seed_valid_i,
    output logic              seed_ready_o,
    input  logic [LfsrDw-1:0] seed_i,
    output logic              rnd_valid_o,
    output logic [OutDw-1:0]  rnd_o,
    output logic              reseed_req_o,
    output logic              zero_seed_o
);

    // True when every index 0..LfsrDw-1 appears exactly once in Perm.
    function automatic bit perm_is_bijection();
        int hits;
        for (int v = 0; v < int'(LfsrDw); v++) begin
            hits = 0;
            for (int i = 0; i < int'(LfsrDw); i++) begin
                if (int'(Perm[i]) == v) hits++;
            end
            if (hits != 1) return 1'b0;
        end
        return 1'b1;
    endfunction

    if (LfsrDw < 4) begin : g_bad_width
        $error("lfsr_perm_gen: LfsrDw must be at least 4");
    end
    if (OutDw < 1 || OutDw > LfsrDw) begin : g_bad_outdw
        $error("lfsr_perm_gen: OutDw must be in 1..LfsrDw");
    end
    if (DefaultSeed == '0) begin : g_bad_seed
        $error("lfsr_perm_gen: DefaultSeed must be nonzero");
    end
    if (!TapMask[LfsrDw-1]) begin : g_bad_taps
        $error("lfsr_perm_gen: TapMask must have its top bit set");
    end
    if (!perm_is_bijection()) begin : g_bad_perm
        $error("lfsr_perm_gen: Perm is not a bijection on 0..LfsrDw-1");
    end

    logic [LfsrDw-1:0] state_q;
    logic [LfsrDw-1:0] state_next;
    logic [LfsrDw-1:0] perm_state;
    logic              seed_accept;
    logic              step;

    // Seeds are always welcome; a seed in the reset cycle is dropped by the
    // reset branches below.
    assign seed_ready_o = 1'b1;
    assign seed_accept  = seed_valid_i && seed_ready_o;

    lfsr_perm_reseed_ctrl #(
        .ReseedInterval (ReseedInterval),
        .StallOnExpiry  (StallOnExpiry)
    ) u_reseed_ctrl (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .en_i          (en_i),
        .seed_accept_i (seed_accept),
        .step_o        (step),
        .rnd_valid_o   (rnd_valid_o),
        .reseed_req_o  (reseed_req_o)
    );

    // One Galois step: shift right, fold the feedback mask in when bit 0 is set.
    always_comb begin
        state_next = {1'b0, state_q[LfsrDw-1:1]} ^ ({LfsrDw{state_q[0]}} & TapMask);
    end

    // State register; a zero seed is replaced by DefaultSeed so the LFSR
    // can never lock up in the all-zero state.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= DefaultSeed;
            zero_seed_o <= 1'b0;
        end else if (seed_accept) begin
            if (seed_i == '0) begin
                state_q     <= DefaultSeed;
                zero_seed_o <= 1'b1;
            end else begin
                state_q <= seed_i;
            end
        end else if (step) begin
            state_q <= state_next;
        end
    end

    // Output permutation straight off the state register.
    always_comb begin
        perm_state = '0;
        for (int i = 0; i < int'(LfsrDw); i++) begin
            perm_state[i] = state_q[Perm[i]];
        end
    end

    assign rnd_o = perm_state[OutDw-1:0];

endmodule

// File: tb/tb_lfsr_perm_gen.sv
// Directed bench for lfsr_perm_gen with a 4-bit LFSR (taps 4'hC, interval 3)
// and a bit-reversing permutation. Two instances share stimulus: one stalls
// at expiry, the other keeps stepping. With the bit-reversing permutation,
// rnd_o is the state read backwards, so expected rnd values below are the
// reversed LFSR states.
module tb_lfsr_perm_gen;

    logic       clk = 1'b0;
    logic       rst_i;
    logic       en_i;
    logic       seed_valid_i;
    logic [3:0] seed_i;

    logic       ready_s, valid_s, req_s, zero_s;
    logic [3:0] rnd_s;
    logic       ready_n, valid_n, req_n, zero_n;
    logic [3:0] rnd_n;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    lfsr_perm_gen #(
        .LfsrDw(4), .OutDw(4), .TapMask(4'hC), .DefaultSeed(4'h1),
        .Perm({2'd0, 2'd1, 2'd2, 2'd3}), .ReseedInterval(3), .StallOnExpiry(1'b1)
    ) dut_stall (
        .clk_i(clk), .rst_i(rst_i), .en_i(en_i), .seed_valid_i(seed_valid_i),
        .seed_ready_o(ready_s), .seed_i(seed_i), .rnd_valid_o(valid_s),
        .rnd_o(rnd_s), .reseed_req_o(req_s), .zero_seed_o(zero_s)
    );

    lfsr_perm_gen #(
        .LfsrDw(4), .OutDw(4), .TapMask(4'hC), .DefaultSeed(4'h1),
        .Perm({2'd0, 2'd1, 2'd2, 2'd3}), .ReseedInterval(3), .StallOnExpiry(1'b0)
    ) dut_free (
        .clk_i(clk), .rst_i(rst_i), .en_i(en_i), .seed_valid_i(seed_valid_i),
        .seed_ready_o(ready_n), .seed_i(seed_i), .rnd_valid_o(valid_n),
        .rnd_o(rnd_n), .reseed_req_o(req_n), .zero_seed_o(zero_n)
    );

    // Advance one clock; inputs change and outputs are sampled at negedge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_i = 1'b1; en_i = 1'b0; seed_valid_i = 1'b0; seed_i = 4'h0;
        tick(); tick();
        rst_i = 1'b0;
    endtask

    task automatic load_seed(input logic [3:0] s, input logic en);
        seed_valid_i = 1'b1; seed_i = s; en_i = en;
        tick();
        seed_valid_i = 1'b0; en_i = 1'b0;
    endtask

    // Reset values, then en_i held while unseeded must not step.
    task automatic test_reset();
        do_reset();
        vectors++;
        if ({ready_s, valid_s, req_s, zero_s, rnd_s} !== {4'b1010, 4'h8}) begin
            $display("FAIL reset_state: got %b/%h want 1010/8",
                     {ready_s, valid_s, req_s, zero_s}, rnd_s);
            miscompares++;
        end
        en_i = 1'b1;
        tick(); tick(); tick();
        en_i = 1'b0;
        vectors++;
        if ({valid_s, req_s, rnd_s, valid_n, req_n, rnd_n} !== {2'b01, 4'h8, 2'b01, 4'h8}) begin
            $display("FAIL unseeded_hold: got %b %h / %b %h want 01 8 / 01 8",
                     {valid_s, req_s}, rnd_s, {valid_n, req_n}, rnd_n);
            miscompares++;
        end
    endtask

    // Seed 1, three steps C,6,3 (rnd 3,6,C); the third step expires the
    // stalling instance, which then holds.
    task automatic test_run_and_expiry();
        logic [3:0] exp_rnd [3] = '{4'h3, 4'h6, 4'hC};
        logic       exp_v   [3] = '{1'b1, 1'b1, 1'b0};
        logic       exp_r   [3] = '{1'b0, 1'b0, 1'b1};
        load_seed(4'h1, 1'b0);
        vectors++;
        if ({valid_s, req_s, rnd_s} !== {2'b10, 4'h8}) begin
            $display("FAIL seeded: got %b %h want 10 8", {valid_s, req_s}, rnd_s);
            miscompares++;
        end
        en_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            vectors++;
            if ({valid_s, req_s, rnd_s} !== {exp_v[i], exp_r[i], exp_rnd[i]}) begin
                $display("FAIL run_step%0d: got %b %h want %b %h", i,
                         {valid_s, req_s}, rnd_s, {exp_v[i], exp_r[i]}, exp_rnd[i]);
                miscompares++;
            end
        end
        tick(); tick();
        en_i = 1'b0;
        vectors++;
        if ({valid_s, req_s, rnd_s} !== {2'b01, 4'hC}) begin
            $display("FAIL expired_hold: got %b %h want 01 c", {valid_s, req_s}, rnd_s);
            miscompares++;
        end
        load_seed(4'h6, 1'b0);
        vectors++;
        if ({valid_s, req_s, rnd_s} !== {2'b10, 4'h6}) begin
            $display("FAIL expired_reseed: got %b %h want 10 6", {valid_s, req_s}, rnd_s);
            miscompares++;
        end
    endtask

    // Non-stalling instance: 15 steps from seed 1 return to 1.
    task automatic test_full_period();
        logic [3:0] exp_rnd [15] = '{4'h3, 4'h6, 4'hC, 4'hB, 4'h5, 4'hA, 4'h7, 4'hE,
                                     4'hF, 4'hD, 4'h9, 4'h1, 4'h2, 4'h4, 4'h8};
        load_seed(4'h1, 1'b0);
        en_i = 1'b1;
        for (int i = 0; i < 15; i++) begin
            tick();
            vectors++;
            if ({valid_n, req_n, rnd_n} !== {1'b1, (i >= 2), exp_rnd[i]}) begin
                $display("FAIL period_step%0d: got %b %h want %b %h", i,
                         {valid_n, req_n}, rnd_n, {1'b1, (i >= 2)}, exp_rnd[i]);
                miscompares++;
            end
        end
        en_i = 1'b0;
    endtask

    // Zero seed becomes DefaultSeed and sets the sticky flag until reset.
    task automatic test_zero_seed();
        load_seed(4'h0, 1'b0);
        vectors++;
        if ({zero_s, zero_n, valid_s, req_s, rnd_s} !== {4'b1110, 4'h8}) begin
            $display("FAIL zero_seed: got %b %h want 1110 8",
                     {zero_s, zero_n, valid_s, req_s}, rnd_s);
            miscompares++;
        end
        load_seed(4'h5, 1'b0);
        vectors++;
        if ({zero_s, rnd_s} !== {1'b1, 4'hA}) begin
            $display("FAIL zero_sticky: got %b %h want 1 a", zero_s, rnd_s);
            miscompares++;
        end
        do_reset();
        vectors++;
        if ({zero_s, zero_n} !== 2'b00) begin
            $display("FAIL zero_cleared: got %b want 00", {zero_s, zero_n});
            miscompares++;
        end
    endtask

    // Seed with en_i in RUN: no step, count restarts (3 more steps to expiry).
    task automatic test_seed_priority();
        logic [3:0] exp_rnd [3] = '{4'h1, 4'h2, 4'h4};
        load_seed(4'h1, 1'b0);
        en_i = 1'b1;
        tick();
        load_seed(4'h9, 1'b1);
        vectors++;
        if ({valid_s, req_s, rnd_s} !== {2'b10, 4'h9}) begin
            $display("FAIL seed_over_step: got %b %h want 10 9", {valid_s, req_s}, rnd_s);
            miscompares++;
        end
        en_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            vectors++;
            if ({req_s, rnd_s} !== {(i == 2), exp_rnd[i]}) begin
                $display("FAIL count_restart%0d: got %b %h want %b %h", i,
                         req_s, rnd_s, (i == 2), exp_rnd[i]);
                miscompares++;
            end
        end
        en_i = 1'b0;
    endtask

    // Reset mid-run discards everything, including a same-cycle seed.
    task automatic test_reset_mid();
        load_seed(4'h1, 1'b0);
        en_i = 1'b1;
        tick();
        rst_i = 1'b1; seed_valid_i = 1'b1; seed_i = 4'h9;
        tick();
        rst_i = 1'b0; seed_valid_i = 1'b0; en_i = 1'b0;
        tick();
        vectors++;
        if ({valid_s, req_s, rnd_s, valid_n, rnd_n} !== {2'b01, 4'h8, 1'b0, 4'h8}) begin
            $display("FAIL reset_mid: got %b %h / %b %h want 01 8 / 0 8",
                     {valid_s, req_s}, rnd_s, valid_n, rnd_n);
            miscompares++;
        end
    endtask

    initial begin
        rst_i = 1'b1; en_i = 1'b0; seed_valid_i = 1'b0; seed_i = 4'h0;
        @(negedge clk);
        test_reset();
        test_run_and_expiry();
        test_full_period();
        test_zero_seed();
        test_seed_priority();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
